// File: rtl/id_pkg.sv
// id_pkg: shared decode definitions for the ID stage.
//   - MIPS opcode constants used by the decoder
//   - ALU operation class encodings carried to EX
//   - ctrl_t: control bundle registered into ID/EX
//   - decode_ctrl / reads_rt: opcode-to-control helpers
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [1:0] ALUOP_ADD    = 2'd0;  // address calculation (lw/sw)
    localparam logic [1:0] ALUOP_BRANCH = 2'd1;
    localparam logic [1:0] ALUOP_RTYPE  = 2'd2;  // EX decodes funct
    localparam logic [1:0] ALUOP_ITYPE  = 2'd3;  // EX decodes opcode

    typedef struct packed {
        logic       memtoreg;
        logic       regwrite;
        logic       memwrite;
        logic       memread;
        logic       alusrc;
        logic [1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        c = CTRL_NOP;
        case (opcode)
            OP_RTYPE: begin
                c.regwrite = 1'b1;
                c.aluop    = ALUOP_RTYPE;
            end
            OP_LW: begin
                c.memread  = 1'b1;
                c.memtoreg = 1'b1;
                c.alusrc   = 1'b1;
                c.regwrite = 1'b1;
                c.aluop    = ALUOP_ADD;
            end
            OP_SW: begin
                c.memwrite = 1'b1;
                c.alusrc   = 1'b1;
                c.aluop    = ALUOP_ADD;
            end
            OP_BEQ, OP_BNE: c.aluop = ALUOP_BRANCH;
            OP_HALT: c = CTRL_NOP;
            default: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                c.aluop    = ALUOP_ITYPE;
            end
        endcase
        return c;
    endfunction

    // Instructions whose rt field is a source operand (not a destination).
    function automatic logic reads_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
               (opcode == OP_BEQ)   || (opcode == OP_BNE);
    endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// reg_file: 2**N_REG_BITS x N_BITS register file.
//   clk, rst            : clock, asynchronous active-high reset (clears all registers)
//   we, waddr, wdata    : write port, captured on the rising edge
//   raddr1/2, rdata1/2  : combinational read ports with write-through bypass
// With R0_ZERO set, register 0 is hard-wired to zero.
module reg_file #(
    parameter int N_BITS     = 32,
    parameter int N_REG_BITS = 5,
    parameter int R0_ZERO    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [N_REG_BITS-1:0] waddr,
    input  logic [N_BITS-1:0]     wdata,
    input  logic [N_REG_BITS-1:0] raddr1,
    input  logic [N_REG_BITS-1:0] raddr2,
    output logic [N_BITS-1:0]     rdata1,
    output logic [N_BITS-1:0]     rdata2
);
    localparam int N_REGS = 2 ** N_REG_BITS;

    logic [N_BITS-1:0] regs [N_REGS];
    logic              wr_en;

    // Writes to r0 are dropped so it can never hold a non-zero value.
    assign wr_en = we && !((R0_ZERO != 0) && (waddr == '0));

    generate
        for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg
            logic [N_BITS-1:0] value_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    value_reg <= '0;
                else if (wr_en && (waddr == N_REG_BITS'(gi)))
                    value_reg <= wdata;
            end
            assign regs[gi] = value_reg;
        end
    endgenerate

    // The bypass lets an instruction in ID see the value WB commits this cycle.
    always_comb begin
        rdata1 = regs[raddr1];
        if (wr_en && (waddr == raddr1))
            rdata1 = wdata;
        rdata2 = regs[raddr2];
        if (wr_en && (waddr == raddr2))
            rdata2 = wdata;
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS instruction-decode stage owning the ID/EX pipeline register.
//   i_clk, i_reset          : clock, asynchronous active-high reset
//   i_valid, i_instruccion, i_pc_4 : IF/ID contents
//   i_wb_*                  : register-file write port
//   i_ex_memread, i_ex_rt   : load in EX (load-use hazard detection)
//   i_ex_*, i_mem_*         : forwarding sources, EX has priority
//   i_ex_ready              : EX accepts ID/EX this cycle
//   o_stall, o_flush, o_branch_target : combinational hazard / branch outputs
//   o_halt                  : sticky halt, cleared only by reset
//   o_valid ... o_aluop     : registered ID/EX contents
module id_stage
    import id_pkg::*;
#(
    parameter int N_BITS     = 32,
    parameter int N_REG_BITS = 5,
    parameter int R0_ZERO    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [N_BITS-1:0]     i_instruccion,
    input  logic [N_BITS-1:0]     i_pc_4,
    input  logic                  i_wb_we,
    input  logic [N_REG_BITS-1:0] i_wb_addr,
    input  logic [N_BITS-1:0]     i_wb_data,
    input  logic                  i_ex_memread,
    input  logic [N_REG_BITS-1:0] i_ex_rt,
    input  logic                  i_ex_we,
    input  logic [N_REG_BITS-1:0] i_ex_addr,
    input  logic [N_BITS-1:0]     i_ex_data,
    input  logic                  i_mem_we,
    input  logic [N_REG_BITS-1:0] i_mem_addr,
    input  logic [N_BITS-1:0]     i_mem_data,
    input  logic                  i_ex_ready,
    output logic                  o_stall,
    output logic                  o_flush,
    output logic [N_BITS-1:0]     o_branch_target,
    output logic                  o_halt,
    output logic                  o_valid,
    output logic [N_BITS-1:0]     o_data1,
    output logic [N_BITS-1:0]     o_data2,
    output logic [N_BITS-1:0]     o_imm,
    output logic [N_REG_BITS-1:0] o_rs,
    output logic [N_REG_BITS-1:0] o_rt,
    output logic [N_REG_BITS-1:0] o_dst,
    output logic                  o_memtoreg,
    output logic                  o_regwrite,
    output logic                  o_memwrite,
    output logic                  o_memread,
    output logic                  o_alusrc,
    output logic [1:0]            o_aluop
);
    logic [5:0]            opcode;
    logic [N_REG_BITS-1:0] rs, rt, rd, dst_next;
    logic [15:0]           imm;
    logic [N_BITS-1:0]     imm_ext, rf_data1, rf_data2, op1, op2;
    ctrl_t                 ctrl;
    logic valid_eff, is_branch, is_halt, load_use, branch_hazard, hazard, taken;

    logic                  halt_reg, valid_reg;
    logic [N_BITS-1:0]     data1_reg, data2_reg, imm_reg;
    logic [N_REG_BITS-1:0] rs_reg, rt_reg, dst_reg;
    ctrl_t                 ctrl_reg;

    assign opcode  = i_instruccion[31:26];
    assign rs      = N_REG_BITS'(i_instruccion[25:21]);
    assign rt      = N_REG_BITS'(i_instruccion[20:16]);
    assign rd      = N_REG_BITS'(i_instruccion[15:11]);
    assign imm     = i_instruccion[15:0];
    assign imm_ext = {{(N_BITS-16){imm[15]}}, imm};
    assign ctrl    = decode_ctrl(opcode);

    reg_file #(
        .N_BITS    (N_BITS),
        .N_REG_BITS(N_REG_BITS),
        .R0_ZERO   (R0_ZERO)
    ) u_reg_file (
        .clk   (i_clk),
        .rst   (i_reset),
        .we    (i_wb_we),
        .waddr (i_wb_addr),
        .wdata (i_wb_data),
        .raddr1(rs),
        .raddr2(rt),
        .rdata1(rf_data1),
        .rdata2(rf_data2)
    );

    // Operand selection: EX result, then MEM result, then register file.
    always_comb begin
        op1 = rf_data1;
        if (i_ex_we && (i_ex_addr != '0) && (i_ex_addr == rs))
            op1 = i_ex_data;
        else if (i_mem_we && (i_mem_addr != '0) && (i_mem_addr == rs))
            op1 = i_mem_data;
        op2 = rf_data2;
        if (i_ex_we && (i_ex_addr != '0) && (i_ex_addr == rt))
            op2 = i_ex_data;
        else if (i_mem_we && (i_mem_addr != '0) && (i_mem_addr == rt))
            op2 = i_mem_data;
    end

    // Once halted, the incoming instruction stream is ignored entirely.
    assign valid_eff = i_valid && !halt_reg;
    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_halt   = (opcode == OP_HALT);

    assign load_use = valid_eff && i_ex_memread && (i_ex_rt != '0) &&
                      ((i_ex_rt == rs) || ((i_ex_rt == rt) && reads_rt(opcode)));

    // The branch compare happens in ID, too early to use a value still in EX.
    assign branch_hazard = valid_eff && is_branch && i_ex_we && (i_ex_addr != '0) &&
                           ((i_ex_addr == rs) || (i_ex_addr == rt));

    assign hazard  = load_use || branch_hazard;
    assign o_stall = hazard || !i_ex_ready;

    assign taken           = (opcode == OP_BEQ) ? (op1 == op2) : (op1 != op2);
    assign o_flush         = valid_eff && is_branch && !o_stall && taken;
    assign o_branch_target = i_pc_4 + (imm_ext << 2);

    assign dst_next = !ctrl.regwrite      ? '0 :
                      (opcode == OP_RTYPE) ? rd : rt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            halt_reg <= 1'b0;
        else if (valid_eff && is_halt && !o_stall)
            halt_reg <= 1'b1;
    end

    // Backpressure freezes ID/EX; hazards, invalid slots and halt insert bubbles.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_reg <= 1'b0;
            data1_reg <= '0;
            data2_reg <= '0;
            imm_reg   <= '0;
            rs_reg    <= '0;
            rt_reg    <= '0;
            dst_reg   <= '0;
            ctrl_reg  <= CTRL_NOP;
        end else if (i_ex_ready) begin
            if (valid_eff && !hazard && !is_halt) begin
                valid_reg <= 1'b1;
                data1_reg <= op1;
                data2_reg <= op2;
                imm_reg   <= imm_ext;
                rs_reg    <= rs;
                rt_reg    <= rt;
                dst_reg   <= dst_next;
                ctrl_reg  <= ctrl;
            end else begin
                valid_reg <= 1'b0;
                data1_reg <= '0;
                data2_reg <= '0;
                imm_reg   <= '0;
                rs_reg    <= '0;
                rt_reg    <= '0;
                dst_reg   <= '0;
                ctrl_reg  <= CTRL_NOP;
            end
        end
    end

    assign o_halt     = halt_reg;
    assign o_valid    = valid_reg;
    assign o_data1    = data1_reg;
    assign o_data2    = data2_reg;
    assign o_imm      = imm_reg;
    assign o_rs       = rs_reg;
    assign o_rt       = rt_reg;
    assign o_dst      = dst_reg;
    assign o_memtoreg = ctrl_reg.memtoreg;
    assign o_regwrite = ctrl_reg.regwrite;
    assign o_memwrite = ctrl_reg.memwrite;
    assign o_memread  = ctrl_reg.memread;
    assign o_alusrc   = ctrl_reg.alusrc;
    assign o_aluop    = ctrl_reg.aluop;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: table-driven directed checks of id_stage plus hand-written
// sequences for load-use, r0, halt and reset corner cases.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] instr, pc_4;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        ex_we;
    logic [4:0]  ex_addr;
    logic [31:0] ex_data;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        ex_ready;

    logic        stall, flush, halt, out_valid;
    logic [31:0] target, data1, data2, imm;
    logic [4:0]  rs, rt, dst;
    logic        memtoreg, regwrite, memwrite, memread, alusrc;
    logic [1:0]  aluop;
    logic [6:0]  ctrl_out;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_R    = 7'b0100010;
    localparam logic [6:0] C_LW   = 7'b1101100;
    localparam logic [6:0] C_SW   = 7'b0010100;
    localparam logic [6:0] C_BR   = 7'b0000001;
    localparam logic [6:0] C_I    = 7'b0100111;

    id_stage #(.N_BITS(32), .N_REG_BITS(5), .R0_ZERO(1)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_instruccion(instr), .i_pc_4(pc_4),
        .i_wb_we(wb_we), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .i_ex_memread(ex_memread), .i_ex_rt(ex_rt),
        .i_ex_we(ex_we), .i_ex_addr(ex_addr), .i_ex_data(ex_data),
        .i_mem_we(mem_we), .i_mem_addr(mem_addr), .i_mem_data(mem_data),
        .i_ex_ready(ex_ready),
        .o_stall(stall), .o_flush(flush), .o_branch_target(target), .o_halt(halt),
        .o_valid(out_valid), .o_data1(data1), .o_data2(data2), .o_imm(imm),
        .o_rs(rs), .o_rt(rt), .o_dst(dst),
        .o_memtoreg(memtoreg), .o_regwrite(regwrite), .o_memwrite(memwrite),
        .o_memread(memread), .o_alusrc(alusrc), .o_aluop(aluop)
    );

    assign ctrl_out = {memtoreg, regwrite, memwrite, memread, alusrc, aluop};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_4;
        logic        valid;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        ex_memread;
        logic [4:0]  ex_rt;
        logic        ex_we;
        logic [4:0]  ex_addr;
        logic [31:0] ex_data;
        logic        mem_we;
        logic [4:0]  mem_addr;
        logic [31:0] mem_data;
        logic        ex_ready;
        logic        exp_stall;
        logic        exp_flush;
        logic        chk_tgt;
        logic [31:0] exp_tgt;
        logic        exp_valid;
        logic [6:0]  exp_ctrl;
        logic        chk_data;
        logic [31:0] exp_data1;
        logic [31:0] exp_data2;
        logic [31:0] exp_imm;
        logic [4:0]  exp_rs;
        logic [4:0]  exp_rt;
        logic [4:0]  exp_dst;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] funct);
        return {6'h00, s, t, d, 5'h00, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        valid = 0; instr = '0; pc_4 = '0;
        wb_we = 0; wb_addr = '0; wb_data = '0;
        ex_memread = 0; ex_rt = '0;
        ex_we = 0; ex_addr = '0; ex_data = '0;
        mem_we = 0; mem_addr = '0; mem_data = '0;
        ex_ready = 1;
    endtask

    task automatic apply(input vec_t v);
        valid = v.valid; instr = v.instr; pc_4 = v.pc_4;
        wb_we = v.wb_we; wb_addr = v.wb_addr; wb_data = v.wb_data;
        ex_memread = v.ex_memread; ex_rt = v.ex_rt;
        ex_we = v.ex_we; ex_addr = v.ex_addr; ex_data = v.ex_data;
        mem_we = v.mem_we; mem_addr = v.mem_addr; mem_data = v.mem_data;
        ex_ready = v.ex_ready;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        clear_inputs();
        wb_we = 1; wb_addr = a; wb_data = d;
        @(posedge clk);
        #1;
        $display("wb r%0d <= %h", a, d);
    endtask

    initial begin
        vec_t d, v;
        d = '0;
        d.ex_ready = 1;

        // V0: WB r5=0x1234 while decoding add r10,r5,r1 (write-through)
        v = d; v.instr = rtype(5, 1, 10, 6'h20); v.pc_4 = 32'h40; v.valid = 1;
        v.wb_we = 1; v.wb_addr = 5; v.wb_data = 32'h1234;
        v.exp_valid = 1; v.exp_ctrl = C_R; v.chk_data = 1;
        v.exp_data1 = 32'h1234; v.exp_data2 = 32'd7; v.exp_imm = 32'h5020;
        v.exp_rs = 5; v.exp_rt = 1; v.exp_dst = 10;
        vecs.push_back(v);
        // V1: beq r1,r2 (7==7), imm 4, pc_4 0x100 -> taken, target 0x110
        v = d; v.instr = itype(6'h04, 1, 2, 16'd4); v.pc_4 = 32'h100; v.valid = 1;
        v.exp_flush = 1; v.chk_tgt = 1; v.exp_tgt = 32'h110;
        v.exp_valid = 1; v.exp_ctrl = C_BR; v.chk_data = 1;
        v.exp_data1 = 7; v.exp_data2 = 7; v.exp_imm = 4; v.exp_rs = 1; v.exp_rt = 2;
        vecs.push_back(v);
        // V2: same beq while WB writes r2=8 -> not taken
        v = d; v.instr = itype(6'h04, 1, 2, 16'd4); v.pc_4 = 32'h100; v.valid = 1;
        v.wb_we = 1; v.wb_addr = 2; v.wb_data = 32'd8;
        v.chk_tgt = 1; v.exp_tgt = 32'h110;
        v.exp_valid = 1; v.exp_ctrl = C_BR; v.chk_data = 1;
        v.exp_data1 = 7; v.exp_data2 = 8; v.exp_imm = 4; v.exp_rs = 1; v.exp_rt = 2;
        vecs.push_back(v);
        // V3: bne r1,r2 (7!=8), imm -1, pc_4 0x200 -> taken, target 0x1FC
        v = d; v.instr = itype(6'h05, 1, 2, 16'hFFFF); v.pc_4 = 32'h200; v.valid = 1;
        v.exp_flush = 1; v.chk_tgt = 1; v.exp_tgt = 32'h1FC;
        v.exp_valid = 1; v.exp_ctrl = C_BR; v.chk_data = 1;
        v.exp_data1 = 7; v.exp_data2 = 8; v.exp_imm = 32'hFFFFFFFF; v.exp_rs = 1; v.exp_rt = 2;
        vecs.push_back(v);
        // V4: sub r11,r1,r2 with EX r2=9 and MEM r2=3 -> EX wins
        v = d; v.instr = rtype(1, 2, 11, 6'h22); v.valid = 1;
        v.ex_we = 1; v.ex_addr = 2; v.ex_data = 32'd9;
        v.mem_we = 1; v.mem_addr = 2; v.mem_data = 32'd3;
        v.exp_valid = 1; v.exp_ctrl = C_R; v.chk_data = 1;
        v.exp_data1 = 7; v.exp_data2 = 9; v.exp_imm = 32'h5822; v.exp_rs = 1; v.exp_rt = 2; v.exp_dst = 11;
        vecs.push_back(v);
        // V5: lw r4,0x10(r1) with MEM r1=0x55 and unrelated EX r9
        v = d; v.instr = itype(6'h23, 1, 4, 16'h10); v.valid = 1;
        v.ex_we = 1; v.ex_addr = 9; v.ex_data = 32'h99;
        v.mem_we = 1; v.mem_addr = 1; v.mem_data = 32'h55;
        v.exp_valid = 1; v.exp_ctrl = C_LW; v.chk_data = 1;
        v.exp_data1 = 32'h55; v.exp_data2 = 0; v.exp_imm = 32'h10; v.exp_rs = 1; v.exp_rt = 4; v.exp_dst = 4;
        vecs.push_back(v);
        // V6: sw r2,8(r1) with an EX write to r0 that must not forward
        v = d; v.instr = itype(6'h2B, 1, 2, 16'd8); v.valid = 1;
        v.ex_we = 1; v.ex_addr = 0; v.ex_data = 32'hDEAD;
        v.exp_valid = 1; v.exp_ctrl = C_SW; v.chk_data = 1;
        v.exp_data1 = 7; v.exp_data2 = 8; v.exp_imm = 8; v.exp_rs = 1; v.exp_rt = 2;
        vecs.push_back(v);
        // V7: addi r7,r1,0x8000 -> negative immediate sign-extended
        v = d; v.instr = itype(6'h08, 1, 7, 16'h8000); v.valid = 1;
        v.exp_valid = 1; v.exp_ctrl = C_I; v.chk_data = 1;
        v.exp_data1 = 7; v.exp_data2 = 0; v.exp_imm = 32'hFFFF8000; v.exp_rs = 1; v.exp_rt = 7; v.exp_dst = 7;
        vecs.push_back(v);
        // V8: backpressure: stall and ID/EX holds V7
        v = d; v.instr = rtype(1, 2, 3, 6'h20); v.valid = 1; v.ex_ready = 0;
        v.exp_stall = 1;
        v.exp_valid = 1; v.exp_ctrl = C_I; v.chk_data = 1;
        v.exp_data1 = 7; v.exp_data2 = 0; v.exp_imm = 32'hFFFF8000; v.exp_rs = 1; v.exp_rt = 7; v.exp_dst = 7;
        vecs.push_back(v);
        // V9: beq r1,r2 with EX writing r1 -> branch stall, no flush, bubble
        v = d; v.instr = itype(6'h04, 1, 2, 16'd4); v.pc_4 = 32'h100; v.valid = 1;
        v.ex_we = 1; v.ex_addr = 1; v.ex_data = 32'd8;
        v.exp_stall = 1; v.chk_tgt = 1; v.exp_tgt = 32'h110;
        v.exp_ctrl = C_NONE;
        vecs.push_back(v);
        // V10: load-use on rt of an R-type -> stall, bubble
        v = d; v.instr = rtype(1, 2, 4, 6'h20); v.valid = 1;
        v.ex_memread = 1; v.ex_rt = 2;
        v.exp_stall = 1; v.exp_ctrl = C_NONE;
        vecs.push_back(v);
        // V11: load to r2, addi r2,r1,1 does not read rt -> no stall
        v = d; v.instr = itype(6'h08, 1, 2, 16'd1); v.valid = 1;
        v.ex_memread = 1; v.ex_rt = 2;
        v.exp_valid = 1; v.exp_ctrl = C_I; v.chk_data = 1;
        v.exp_data1 = 7; v.exp_data2 = 8; v.exp_imm = 1; v.exp_rs = 1; v.exp_rt = 2; v.exp_dst = 2;
        vecs.push_back(v);
        // V12: load to r0 never stalls; add r4,r0,r1
        v = d; v.instr = rtype(0, 1, 4, 6'h20); v.valid = 1;
        v.ex_memread = 1; v.ex_rt = 0;
        v.exp_valid = 1; v.exp_ctrl = C_R; v.chk_data = 1;
        v.exp_data1 = 0; v.exp_data2 = 7; v.exp_imm = 32'h2020; v.exp_rs = 0; v.exp_rt = 1; v.exp_dst = 4;
        vecs.push_back(v);
        // V13: invalid slot holding a would-be-taken beq -> no flush, bubble
        v = d; v.instr = itype(6'h04, 1, 1, 16'd4); v.valid = 0;
        v.exp_ctrl = C_NONE;
        vecs.push_back(v);

        // ---------------- reset ----------------
        clear_inputs();
        rst = 1;
        #12;
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_halt", {31'd0, halt}, 32'd0);
        check("reset_data1", data1, 32'd0);
        check("reset_ctrl", {25'd0, ctrl_out}, 32'd0);
        @(negedge clk);
        rst = 0;
        $display("reset released");

        wb_write(5'd1, 32'd7);
        wb_write(5'd2, 32'd7);

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
            check($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].exp_flush});
            if (vecs[i].chk_tgt)
                check($sformatf("v%0d_target", i), target, vecs[i].exp_tgt);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("v%0d_ctrl", i), {25'd0, ctrl_out}, {25'd0, vecs[i].exp_ctrl});
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d_data1", i), data1, vecs[i].exp_data1);
                check($sformatf("v%0d_data2", i), data2, vecs[i].exp_data2);
                check($sformatf("v%0d_imm", i), imm, vecs[i].exp_imm);
                check($sformatf("v%0d_regs", i), {17'd0, rs, rt, dst},
                      {17'd0, vecs[i].exp_rs, vecs[i].exp_rt, vecs[i].exp_dst});
            end
            $display("vec %0d instr=%h stall=%b flush=%b valid=%b data1=%h data2=%h ctrl=%b",
                     i, vecs[i].instr, stall, flush, out_valid, data1, data2, ctrl_out);
        end

        // ---------------- load-use: one stall cycle then forwarded operand ----------------
        @(negedge clk);
        clear_inputs();
        valid = 1; instr = rtype(3, 1, 4, 6'h20);
        ex_memread = 1; ex_rt = 3;
        #1;
        check("lu_stall_on", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        check("lu_bubble", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        ex_memread = 0; ex_rt = 0;
        mem_we = 1; mem_addr = 3; mem_data = 32'h3333;
        #1;
        check("lu_stall_off", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        check("lu_valid", {31'd0, out_valid}, 32'd1);
        check("lu_data1", data1, 32'h3333);
        check("lu_data2", data2, 32'd7);
        $display("load-use: valid=%b data1=%h", out_valid, data1);

        // ---------------- r0 stays zero ----------------
        @(negedge clk);
        clear_inputs();
        wb_we = 1; wb_addr = 0; wb_data = 32'hABCD;
        valid = 1; instr = rtype(0, 1, 4, 6'h20);
        @(posedge clk);
        #1;
        check("r0_bypass", data1, 32'd0);
        @(negedge clk);
        wb_we = 0;
        @(posedge clk);
        #1;
        check("r0_read", data1, 32'd0);
        $display("r0 read: data1=%h", data1);

        // ---------------- halt delayed by backpressure, then sticky ----------------
        @(negedge clk);
        clear_inputs();
        valid = 1; instr = {6'h3F, 26'd0}; ex_ready = 0;
        #1;
        check("halt_bp_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        check("halt_held_off", {31'd0, halt}, 32'd0);
        @(negedge clk);
        ex_ready = 1;
        @(posedge clk);
        #1;
        check("halt_set", {31'd0, halt}, 32'd1);
        check("halt_valid", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            valid = 1; instr = rtype(1, 2, 4, 6'h20);
            @(posedge clk);
            #1;
            check($sformatf("halted_valid%0d", k), {31'd0, out_valid}, 32'd0);
            check($sformatf("halted_halt%0d", k), {31'd0, halt}, 32'd1);
            $display("halted cycle %0d: halt=%b valid=%b", k, halt, out_valid);
        end
        @(negedge clk);
        valid = 1; instr = itype(6'h04, 1, 1, 16'd4);
        #1;
        check("halted_no_flush", {31'd0, flush}, 32'd0);
        rst = 1;
        #1;
        check("rst_clears_halt", {31'd0, halt}, 32'd0);
        check("rst_clears_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 0;
        $display("reset after halt: halt=%b", halt);

        // ---------------- reset mid-stall ----------------
        @(negedge clk);
        clear_inputs();
        valid = 1; instr = rtype(3, 1, 4, 6'h20);
        ex_memread = 1; ex_rt = 3;
        #1;
        check("ms_stall_on", {31'd0, stall}, 32'd1);
        rst = 1; ex_memread = 0; ex_rt = 0;
        #1;
        check("ms_stall_off", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 0;
        instr = rtype(1, 2, 4, 6'h20);
        @(posedge clk);
        #1;
        check("ms_rf_cleared1", data1, 32'd0);
        check("ms_rf_cleared2", data2, 32'd0);
        check("ms_valid", {31'd0, out_valid}, 32'd1);
        $display("after reset: valid=%b data1=%h data2=%h", out_valid, data1, data2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
